// File: rtl/bank4_burst_arbiter_pkg.sv
// Shared definitions for the four-word bank write arbiter.
//   - Burst FSM state encodings (ST_IDLE, ST_COLLECT, ST_COMMIT)
//   - Burst length and the derived counter / stage-index widths
//   - Default data width, requester count and owner index width
package bank_arb_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int NUM_REQ_DEF     = 4;
  localparam int IDX_W_DEF       = 2;

  // Every burst is exactly one word per bank register.
  localparam int WORDS_PER_BURST = 4;
  // Counter must be able to hold WORDS_PER_BURST itself (burst complete).
  localparam int CNT_W           = $clog2(WORDS_PER_BURST + 1);
  localparam int STAGE_IDX_W     = $clog2(WORDS_PER_BURST);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/bank4_burst_arbiter_if.sv
// Requester-side bus of the bank arbiter.
//   req    : per-requester level request, held for the whole burst
//   wdata  : flattened write data, requester i on [i*DATA_W +: DATA_W]
//   wvalid : per-requester word valid
//   wready : one-hot word ready (owner only, while collecting)
//   grant  : one-hot ownership indication
// master = requester side, slave = arbiter side.
interface bank4_burst_arbiter_if
  import bank_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        wvalid;
  logic [NUM_REQ-1:0]        wready;
  logic [NUM_REQ-1:0]        grant;

  modport master (output req, wdata, wvalid, input  wready, grant);
  modport slave  (input  req, wdata, wvalid, output wready, grant);

endinterface

// File: rtl/bank4_burst_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   rr_ptr : index with highest priority this round
//   found  : at least one request is set
//   winner : first set request scanning circularly upward from rr_ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   winner
);

  int               idx;
  logic [IDX_W-1:0] idx_v;

  always_comb begin
    // NOTE: every variable gets a default before the scan so no path can
    // leave one unassigned and infer a latch.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_v  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(rr_ptr) + k) % NUM_REQ;
      idx_v = IDX_W'(idx);
      if (!found && req[idx_v]) begin
        found  = 1'b1;
        winner = idx_v;
      end
    end
  end

endmodule

// File: rtl/bank4_burst_arbiter.sv
// Round-robin write arbiter and burst sequencer for a four-word bank.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus          : requester bus (slave side), see bank4_burst_arbiter_if
//   owner        : index of the current owner, meaningful while busy
//   busy         : a burst is in COLLECT or COMMIT
//   bank_in_1..4 : staged words in burst order, to the bank inputs
//   bank_enable  : one-cycle strobe that updates all bank words at once
module bank4_burst_arbiter
  import bank_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  bank4_burst_arbiter_if.slave   bus,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy,
  output logic [DATA_W-1:0]      bank_in_1,
  output logic [DATA_W-1:0]      bank_in_2,
  output logic [DATA_W-1:0]      bank_in_3,
  output logic [DATA_W-1:0]      bank_in_4,
  output logic                   bank_enable
);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0]  stage [WORDS_PER_BURST];

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   owner_next;
  logic [DATA_W-1:0]  req_word [NUM_REQ];

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .found  (found),
    .winner (winner)
  );

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign req_word[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

  assign owner_next = IDX_W'((int'(owner) + 1) % NUM_REQ);

  // Ready only while words are still missing; the owner's grant bit is the
  // one-hot mask, so no other requester can ever see ready.
  assign bus.wready = (state == ST_COLLECT && count < CNT_W'(WORDS_PER_BURST))
                      ? grant : '0;
  assign bus.grant  = grant;

  assign bank_in_1 = stage[0];
  assign bank_in_2 = stage[1];
  assign bank_in_3 = stage[2];
  assign bank_in_4 = stage[3];

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking would let later statements see half-updated values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      rr_ptr      <= '0;
      owner       <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      bank_enable <= 1'b0;
      // NOTE: the staging words drive the bank inputs directly and must read
      // 0 out of reset, so this small register array is reset explicitly.
      for (int i = 0; i < WORDS_PER_BURST; i++) stage[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            owner <= winner;
            grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            busy  <= 1'b1;
            count <= '0;
            state <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (!bus.req[owner]) begin
            // Abort: a word offered on this same edge is discarded.
            grant  <= '0;
            busy   <= 1'b0;
            count  <= '0;
            rr_ptr <= owner_next;
            state  <= ST_IDLE;
          end else if (bus.wvalid[owner]) begin
            stage[count[STAGE_IDX_W-1:0]] <= req_word[owner];
            count <= count + 1'b1;
            if (count == CNT_W'(WORDS_PER_BURST - 1)) begin
              bank_enable <= 1'b1;
              state       <= ST_COMMIT;
            end
          end
        end

        ST_COMMIT: begin
          // req is not looked at here: a commit always completes.
          bank_enable <= 1'b0;
          grant       <= '0;
          busy        <= 1'b0;
          count       <= '0;
          rr_ptr      <= owner_next;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bank4_burst_arbiter.md
Name: bank4_burst_arbiter

Overview:
- Round-robin write arbiter and sequencer for a four-word 32-bit register bank. The bank is the Tetris row/piece state store: four 32-bit registers with a shared enable.
- Grants the bank to one of NUM_REQ requesters and collects a 4-word burst from the winner into staging registers.
- Issues a single-cycle bank_enable so all four bank registers update atomically.
- Sits between the game-logic producers (piece mover, row clearer, spawner, debug loader) and the bank.

Parameters:
- DATA_W, 32, width of each bank word.
- NUM_REQ, 4, number of requesters.
- IDX_W, 2, width of the owner index; must satisfy 2^IDX_W >= NUM_REQ.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset: 0 clears all state immediately.
- req  in  NUM_REQ  per-requester bus request; level, held for the whole burst.
- wdata  in  NUM_REQ*DATA_W  flattened write data; requester i uses bits [i*DATA_W +: DATA_W].
- wvalid  in  NUM_REQ  per-requester word valid.
- wready  out  NUM_REQ  one-hot word ready; only the owner's bit can be 1.
- grant  out  NUM_REQ  one-hot ownership indication.
- owner  out  IDX_W  index of the current owner; meaningful only while busy=1.
- busy  out  1  a burst is in progress (COLLECT or COMMIT).
- bank_in_1..bank_in_4  out  DATA_W each  staged words in burst order, to the bank inputs.
- bank_enable  out  1  one-cycle commit strobe to the bank enable.

Behaviour:
- Reset (reset=0, asynchronous):
  - grant, wready, owner, busy, bank_enable and bank_in_1..4 all go to 0.
  - Word count goes to 0, rr_ptr goes to 0, state goes to IDLE.
- State machine: IDLE -> COLLECT -> COMMIT -> IDLE. Encoded as shared-package constants.
- IDLE:
  - If req != 0, select the first set req bit scanning circularly from rr_ptr upward.
  - On the next edge: load owner, assert grant[owner], set busy=1, count=0, go to COLLECT.
  - Latency from req sample to grant is 1 cycle.
  - If req == 0, stay in IDLE with all outputs unchanged.
- COLLECT:
  - wready[owner]=1; all other wready bits are 0.
  - A word is accepted on any edge where wvalid[owner] and wready[owner] are both 1.
  - On accept: stage[count] <= owner's wdata slice, then count increments. Word 0 drives bank_in_1, word 3 drives bank_in_4.
  - wready drops combinationally once count==4.
  - The 4th accept moves the FSM to COMMIT.
  - wvalid from non-owners is ignored. Gaps (wvalid=0) simply stall the burst, with no timeout.
- COMMIT:
  - bank_enable=1 for exactly one cycle and wready=0.
  - bank_in_1..4 are stable and equal to the staged words.
  - Next edge: rr_ptr <= (owner+1) mod NUM_REQ, grant=0, busy=0, go to IDLE.
- Minimum transaction is 6 cycles (1 arbitrate + 4 words + 1 commit). Back-to-back bursts incur the 1-cycle IDLE arbitration.
- Abort:
  - Condition: req[owner] sampled 0 during COLLECT.
  - Next edge: go to IDLE, grant=0, busy=0, count=0, rr_ptr <= owner+1 mod NUM_REQ.
  - No bank_enable is issued. bank_in keeps its partially staged values, which is harmless because the bank is not enabled.
  - A wvalid accepted on the same edge as the abort is discarded.
- Dropping req during COMMIT has no effect; the commit completes.
- bank_in words change only on accepted writes, so they hold between bursts.
- No output ever shows more than one grant or wready bit set.
- Reset asserted mid-burst takes effect immediately. No bank_enable is issued and the bank keeps its old contents.

Decomposition:
- Shared package (bank_arb_pkg):
  - state encodings ST_IDLE, ST_COLLECT, ST_COMMIT;
  - WORDS_PER_BURST=4;
  - default DATA_W/NUM_REQ.
- One sub-module: rr_pick. It is combinational: given req and rr_ptr it returns a found flag and the winner index, using a circular priority scan.
- Staging registers, counter and FSM stay in bank4_burst_arbiter.

Test Plan:
1. Single burst:
   - Stimulus: reset released, req=0b0010, requester 1 sends 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
   - Required: grant=0b0010 one cycle after req, and bank_enable pulses exactly once on cycle 6.
   - bank_in_1..4 equal those four words in order; rr_ptr becomes 2.
2. Round-robin fairness:
   - Stimulus: req=0b1111 held continuously, each owner sends 4 words.
   - Required: grant order is 0,1,2,3,0 and every burst ends with exactly one bank_enable.
3. Stalls and foreign valids:
   - Stimulus: owner 2 toggles wvalid 1,0,0,1,1,0,1 while requester 3 holds wvalid=1 with data 0xDEADBEEF.
   - Required: only requester 2's words are captured, bank_in never equals 0xDEADBEEF, and the commit follows the 4th accept.
4. Abort:
   - Stimulus: owner 0 sends 2 words, then drops req.
   - Required: no bank_enable, grant=0 on the next cycle, and the next grant goes to requester 1 when req=0b0011.
5. Reset mid-burst:
   - Stimulus: reset=0 asynchronously after word 3.
   - Required: all outputs are 0 immediately without waiting for a clock edge, and no bank_enable occurs.
   - After release, req=0b1000 produces grant=0b1000, starting from rr_ptr=0.
6. Late req drop:
   - Stimulus: req[owner] drops in the COMMIT cycle.
   - Required: bank_enable still pulses once and the FSM returns to IDLE.
